bcd_seven_seg_scan: RTL and testbench
=====================================

# bcd_seven_seg_scan

Time-multiplexed 7-segment display driver that sits directly downstream of the binary-to-BCD converter. It captures the packed BCD vector whenever the converter pulses its data-valid. It scans the digits one at a time onto a shared active-low segment bus, with a blanking gap between digits to suppress ghosting. New values take effect only at frame boundaries, so a displayed number never tears mid-scan.

## Interface
- DECIMAL_DIGITS, 3, number of BCD digits and anodes; must be ≥1.
- REFRESH_COUNT, 50000, clock cycles each digit is lit; must be ≥1.
- GAP_COUNT, 500, clock cycles all digits are dark between digits; must be ≥1.

- i_Clock  input  1  single system clock, all logic on rising edge.
- i_Rst_L  input  1  asynchronous, active-low reset.
- i_BCD  input  DECIMAL_DIGITS*4  packed BCD, digit 0 in bits [3:0].
- i_DV  input  1  one-cycle strobe; i_BCD is valid on the same cycle.
- o_Anode  output  DECIMAL_DIGITS  active-low digit enables; bit n drives digit n.
- o_Segments  output  7  active-low segments {g,f,e,d,c,b,a}; bit 0 is segment a.
- o_Frame_Start  output  1  one-cycle pulse when digit 0 begins its lit slot.

## Operation
- Registers:
  - r_Shadow: last captured BCD value, plus a pending flag.
  - r_Active: the value being displayed.
  - r_Digit: digit index.
  - r_Count: cycle counter, width $clog2 of max(REFRESH_COUNT, GAP_COUNT)+1.
- All outputs are registered.
- States:
  - s_IDLE: nothing is shown yet. o_Anode is all 1s and o_Segments = 7'h7F.
    - On i_DV: r_Active <= i_BCD, r_Digit <= 0, r_Count <= 0, go to s_ON.
  - s_ON: o_Anode[r_Digit] = 0, other anodes 1, o_Segments = decode of digit r_Digit of r_Active.
    - After REFRESH_COUNT cycles, go to s_GAP with r_Count cleared.
  - s_GAP: all anodes 1, o_Segments = 7'h7F.
    - After GAP_COUNT cycles, increment r_Digit and go to s_ON.
    - If r_Digit == DECIMAL_DIGITS-1, r_Digit wraps to 0 instead (the frame boundary). At that point, if pending is set, r_Active <= r_Shadow and pending is cleared.
- Capture: i_DV in s_ON or s_GAP sets r_Shadow <= i_BCD and pending <= 1. Back-to-back strobes overwrite; the latest value wins.
- Simultaneous i_DV and frame-boundary edge: r_Active <= i_BCD directly and pending is cleared (the newest value wins).
- Decode (active-low), for digits 0-9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex, 7-bit).
- Invalid digit (>9) shows a dash, 7'h3F (segment g only).
- o_Frame_Start is high for exactly the first cycle of s_ON with r_Digit == 0, including the first entry from s_IDLE.
- The block never returns to s_IDLE except via reset.

## Timing
- Reset (asynchronous assert):
  - Outputs go immediately to o_Anode = all 1s, o_Segments = 7'h7F, o_Frame_Start = 0.
  - State goes to s_IDLE; r_Shadow, r_Active and pending are cleared; r_Digit = 0.
- Deassertion is sampled on the next rising edge; the block is usable from that edge.
- Reset mid-scan discards any pending value.
- Latency in s_IDLE: with i_DV at edge k, the anode of digit 0 is low and o_Frame_Start = 1 from edge k+1.
- Latency while scanning: a captured value appears at the next frame boundary. Worst case is DECIMAL_DIGITS*(REFRESH_COUNT+GAP_COUNT) cycles.
- Frame period is exactly DECIMAL_DIGITS*(REFRESH_COUNT+GAP_COUNT) cycles.
- At most one anode is ever low. At least GAP_COUNT dark cycles separate any two lit digits.
- i_BCD is sampled only on i_DV cycles.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - During s_ON, any digit n > 0 is blanked when digits n through DECIMAL_DIGITS-1 of r_Active are all zero.
  - Blanked means o_Anode stays all 1s and o_Segments = 7'h7F; slot timing is unchanged.
  - Digit 0 is always shown, so value 0 displays as "0".
- Not defined: every digit is displayed, including leading zeros.

## Test plan
All scenarios use DECIMAL_DIGITS=3, REFRESH_COUNT=4, GAP_COUNT=1.
- Reset, no i_DV for 50 cycles -> o_Anode = 3'b111, o_Segments = 7'h7F throughout, o_Frame_Start never high.
- i_DV with i_BCD = 12'h125 at edge k:
  - From k+1: o_Frame_Start pulses; digit 0 is shown as 7'h12 for 4 cycles with o_Anode = 3'b110.
  - Then 1 dark cycle, then 7'h24 on 3'b101, then 7'h79 on 3'b011.
  - The pattern repeats every 15 cycles.
- While showing 125, i_DV with 12'h907 mid-frame -> the remainder of the frame still shows 125; 907 appears starting with the next o_Frame_Start.
- i_BCD = 12'h00A -> digit 0 shows the dash 7'h3F. With LEADING_ZERO_BLANK_EN, digits 1-2 are dark (anodes 1); without it, both show 7'h40.
- i_BCD = 12'h000 with LEADING_ZERO_BLANK_EN -> only digit 0 is lit, showing 7'h40.
- Assert i_Rst_L low mid-s_ON -> outputs go dark with no clock edge. After release, no display until a new i_DV; the earlier pending value is not shown.

Source files
------------

// File: rtl/bcd_seven_seg_scan.sv
// -----------------------------------------------------------------------------
// bcd_seven_seg_scan
//
// Time-multiplexed 7-segment display driver. Captures a packed BCD vector on
// each i_DV strobe and scans its digits one at a time onto a shared active-low
// segment bus. A dark gap separates consecutive digits to suppress ghosting.
// A new value is only adopted at a frame boundary (wrap from the last digit
// back to digit 0), so a number is never torn mid-scan.
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   When defined, a digit n > 0 is blanked while digits n..DECIMAL_DIGITS-1
//   of the displayed value are all zero. Slot timing is unchanged and digit 0
//   is always shown.
//
// Parameters:
//   DECIMAL_DIGITS  number of BCD digits / anodes (>= 1)
//   REFRESH_COUNT   cycles each digit is lit (>= 1)
//   GAP_COUNT       dark cycles between digits (>= 1)
//
// Ports:
//   i_Clock        system clock, rising edge
//   i_Rst_L        asynchronous active-low reset
//   i_BCD          packed BCD, digit 0 in bits [3:0]
//   i_DV           one-cycle strobe qualifying i_BCD
//   o_Anode        active-low digit enables, bit n drives digit n
//   o_Segments     active-low segments {g,f,e,d,c,b,a}
//   o_Frame_Start  one-cycle pulse on the first lit cycle of digit 0
// -----------------------------------------------------------------------------
module bcd_seven_seg_scan #(
  parameter int DECIMAL_DIGITS = 3,
  parameter int REFRESH_COUNT  = 50000,
  parameter int GAP_COUNT      = 500
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_L,
  input  logic [DECIMAL_DIGITS*4-1:0]   i_BCD,
  input  logic                          i_DV,
  output logic [DECIMAL_DIGITS-1:0]     o_Anode,
  output logic [6:0]                    o_Segments,
  output logic                          o_Frame_Start
);

  localparam int MAX_COUNT = (REFRESH_COUNT > GAP_COUNT) ? REFRESH_COUNT : GAP_COUNT;
  localparam int CNT_W     = $clog2(MAX_COUNT + 1);
  localparam int DIGIT_W   = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
  localparam int BCD_W     = DECIMAL_DIGITS * 4;

  localparam logic [CNT_W-1:0]   REFRESH_LAST = CNT_W'(REFRESH_COUNT - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(GAP_COUNT - 1);
  localparam logic [DIGIT_W-1:0] LAST_DIGIT   = DIGIT_W'(DECIMAL_DIGITS - 1);

  typedef enum logic [1:0] {
    s_IDLE = 2'd0,
    s_ON   = 2'd1,
    s_GAP  = 2'd2
  } state_t;

  state_t             r_State,   next_state;
  logic [BCD_W-1:0]   r_Shadow,  next_shadow;
  logic               r_Pending, next_pending;
  logic [BCD_W-1:0]   r_Active,  next_active;
  logic [DIGIT_W-1:0] r_Digit,   next_digit;
  logic [CNT_W-1:0]   r_Count,   next_count;

  logic [DECIMAL_DIGITS-1:0] anode_d;
  logic [6:0]                segments_d;
  logic                      frame_start_d;
  logic [3:0]                digit_val;
  logic                      blank;

  // Active-low decode; anything above 9 shows a dash (segment g only).
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State   <= s_IDLE;
      r_Shadow  <= '0;
      r_Pending <= 1'b0;
      r_Active  <= '0;
      r_Digit   <= '0;
      r_Count   <= '0;
    end else begin
      r_State   <= next_state;
      r_Shadow  <= next_shadow;
      r_Pending <= next_pending;
      r_Active  <= next_active;
      r_Digit   <= next_digit;
      r_Count   <= next_count;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state   = r_State;
    next_shadow  = r_Shadow;
    next_pending = r_Pending;
    next_active  = r_Active;
    next_digit   = r_Digit;
    next_count   = r_Count;

    case (r_State)
      s_IDLE: begin
        if (i_DV) begin
          next_active = i_BCD;
          next_digit  = '0;
          next_count  = '0;
          next_state  = s_ON;
        end
      end

      s_ON: begin
        if (i_DV) begin
          next_shadow  = i_BCD;
          next_pending = 1'b1;
        end
        if (r_Count == REFRESH_LAST) begin
          next_count = '0;
          next_state = s_GAP;
        end else begin
          next_count = r_Count + CNT_W'(1);
        end
      end

      s_GAP: begin
        if (i_DV) begin
          next_shadow  = i_BCD;
          next_pending = 1'b1;
        end
        if (r_Count == GAP_LAST) begin
          next_count = '0;
          next_state = s_ON;
          if (r_Digit == LAST_DIGIT) begin
            // Frame boundary: a strobe on this very edge beats the shadow.
            next_digit = '0;
            if (i_DV) begin
              next_active  = i_BCD;
              next_pending = 1'b0;
            end else if (r_Pending) begin
              next_active  = r_Shadow;
              next_pending = 1'b0;
            end
          end else begin
            next_digit = r_Digit + DIGIT_W'(1);
          end
        end else begin
          next_count = r_Count + CNT_W'(1);
        end
      end

      default: next_state = s_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode, computed from the next state so the registered outputs
  // line up with the state they describe.
  // ---------------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;
`endif

  always_comb begin
    anode_d       = '1;
    segments_d    = 7'h7F;
    frame_start_d = 1'b0;
    digit_val     = 4'd0;
    blank         = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    upper_zero    = 1'b1;
`endif

    if (next_state == s_ON) begin
      for (int n = 0; n < DECIMAL_DIGITS; n++) begin
        if (next_digit == DIGIT_W'(n)) digit_val = next_active[n*4 +: 4];
      end

`ifdef LEADING_ZERO_BLANK_EN
      // Walk down from the most significant digit; a digit is blank while
      // it and everything above it are zero. Digit 0 is never visited.
      for (int n = DECIMAL_DIGITS - 1; n >= 1; n--) begin
        upper_zero = upper_zero & (next_active[n*4 +: 4] == 4'd0);
        if ((next_digit == DIGIT_W'(n)) && upper_zero) blank = 1'b1;
      end
`endif

      if (!blank) begin
        for (int n = 0; n < DECIMAL_DIGITS; n++) begin
          if (next_digit == DIGIT_W'(n)) anode_d[n] = 1'b0;
        end
        segments_d = seg_decode(digit_val);
      end

      // Entry into the digit-0 lit slot, from either s_IDLE or s_GAP.
      frame_start_d = (r_State != s_ON) && (next_digit == '0);
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Anode       <= '1;
      o_Segments    <= 7'h7F;
      o_Frame_Start <= 1'b0;
    end else begin
      o_Anode       <= anode_d;
      o_Segments    <= segments_d;
      o_Frame_Start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_bcd_seven_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_seven_seg_scan
//
// Self-checking bench for bcd_seven_seg_scan with DECIMAL_DIGITS=3,
// REFRESH_COUNT=4, GAP_COUNT=1 (15-cycle frame). A frame-position model
// predicts the outputs every cycle; directed steps add literal expectations.
// Honours LEADING_ZERO_BLANK_EN when the build defines it.
// -----------------------------------------------------------------------------
module tb_bcd_seven_seg_scan;

  localparam int D     = 3;
  localparam int R     = 4;
  localparam int G     = 1;
  localparam int SLOT  = R + G;
  localparam int FRAME = D * SLOT;

  localparam logic [6:0] SEG_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic          clk;
  logic          rst_n;
  logic [11:0]   bcd;
  logic          dv;
  logic [2:0]    anode;
  logic [6:0]    segments;
  logic          frame_start;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 0;

  bcd_seven_seg_scan #(
    .DECIMAL_DIGITS (D),
    .REFRESH_COUNT  (R),
    .GAP_COUNT      (G)
  ) dut (
    .i_Clock       (clk),
    .i_Rst_L       (rst_n),
    .i_BCD         (bcd),
    .i_DV          (dv),
    .o_Anode       (anode),
    .o_Segments    (segments),
    .o_Frame_Start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: position within the frame plus the value on display.
  // ---------------------------------------------------------------------------
  logic        m_run  = 1'b0;
  int          m_t    = 0;
  logic [11:0] m_act  = '0;
  logic [11:0] m_sh   = '0;
  logic        m_pend = 1'b0;
  int          m_nt;

  assign m_nt = (m_t + 1) % FRAME;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_t    <= 0;
      m_act  <= '0;
      m_sh   <= '0;
      m_pend <= 1'b0;
    end else if (!m_run) begin
      if (dv) begin
        m_run <= 1'b1;
        m_t   <= 0;
        m_act <= bcd;
      end
    end else begin
      m_t <= m_nt;
      if (m_nt == 0) begin
        if (dv) begin
          m_act  <= bcd;
          m_pend <= 1'b0;
        end else if (m_pend) begin
          m_act  <= m_sh;
          m_pend <= 1'b0;
        end
      end else if (dv) begin
        m_sh   <= bcd;
        m_pend <= 1'b1;
      end
    end
  end

  logic [2:0] e_an;
  logic [6:0] e_seg;
  logic       e_fs;
  int         e_slot;
  int         e_pos;
  logic [3:0] e_dig;
  logic       e_show;

  always_comb begin
    e_an   = 3'b111;
    e_seg  = 7'h7F;
    e_fs   = 1'b0;
    e_slot = m_t / SLOT;
    e_pos  = m_t % SLOT;
    e_dig  = 4'((m_act >> (4 * e_slot)) & 12'hF);
    e_show = 1'b1;
    if (m_run) begin
      e_fs = (m_t == 0);
      if (e_pos < R) begin
`ifdef LEADING_ZERO_BLANK_EN
        if (e_slot > 0 && (m_act >> (4 * e_slot)) == 12'd0) e_show = 1'b0;
`endif
        if (e_show) begin
          e_an  = ~(3'b001 << e_slot);
          e_seg = (e_dig > 4'd9) ? 7'h3F : SEG_TBL[e_dig];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_anode", 32'(anode), 32'(e_an));
      check("cyc_seg", 32'(segments), 32'(e_seg));
      check("cyc_frame_start", 32'(frame_start), 32'(e_fs));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic drive_dv(input logic [11:0] v);
    @(posedge clk); #2;
    dv  = 1'b1;
    bcd = v;
    @(posedge clk); #2;
    dv  = 1'b0;
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("frame_start_seen", 32'(frame_start), 32'd1);
  endtask

  logic [2:0] an_tbl  [FRAME] = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b111,
                                  3'b101, 3'b101, 3'b101, 3'b101, 3'b111,
                                  3'b011, 3'b011, 3'b011, 3'b011, 3'b111};
  logic [6:0] seg_tbl [FRAME] = '{7'h12, 7'h12, 7'h12, 7'h12, 7'h7F,
                                  7'h24, 7'h24, 7'h24, 7'h24, 7'h7F,
                                  7'h79, 7'h79, 7'h79, 7'h79, 7'h7F};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    dv    = 1'b0;
    bcd   = '0;
    #1 cmp_en = 1;

    // Reset, then 50 idle cycles: dark throughout.
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_anode", 32'(anode), 32'h7);
    check("idle_seg", 32'(segments), 32'h7F);

    // First value from idle: two full frames against a literal table.
    drive_dv(12'h125);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      check("lit_anode", 32'(anode), 32'(an_tbl[i % FRAME]));
      check("lit_seg", 32'(segments), 32'(seg_tbl[i % FRAME]));
      check("lit_fs", 32'(frame_start), (i % FRAME == 0) ? 32'd1 : 32'd0);
    end

    // Mid-frame update waits for the next frame boundary.
    repeat (3) @(negedge clk);
    drive_dv(12'h907);
    wait_fs();
    check("upd_seg", 32'(segments), 32'h78);
    check("upd_anode", 32'(anode), 32'h6);

    // Invalid digit shows a dash; leading zeros depend on the build.
    drive_dv(12'h00A);
    wait_fs();
    check("dash_seg", 32'(segments), 32'h3F);
    repeat (SLOT) @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
    check("lz_d1_anode", 32'(anode), 32'h7);
    check("lz_d1_seg", 32'(segments), 32'h7F);
`else
    check("lz_d1_anode", 32'(anode), 32'h5);
    check("lz_d1_seg", 32'(segments), 32'h40);
`endif

    // Zero value: digit 0 always shows "0".
    drive_dv(12'h000);
    wait_fs();
    check("zero_d0_seg", 32'(segments), 32'h40);
    check("zero_d0_anode", 32'(anode), 32'h6);
    repeat (2 * SLOT) @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
    check("zero_d2_anode", 32'(anode), 32'h7);
`else
    check("zero_d2_anode", 32'(anode), 32'h3);
`endif

    // Strobe on the frame-boundary edge beats an older pending value.
    wait_fs();
    drive_dv(12'h222);
    repeat (FRAME - 4) @(posedge clk);
    drive_dv(12'h314);
    @(negedge clk);
    check("bnd_fs", 32'(frame_start), 32'd1);
    check("bnd_seg", 32'(segments), 32'h19);

    // Back-to-back strobes: the latest one wins.
    drive_dv(12'h111);
    drive_dv(12'h666);
    wait_fs();
    check("b2b_seg", 32'(segments), 32'h02);

    // Asynchronous reset mid-lit-slot with a pending value.
    drive_dv(12'h456);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (anode == 3'b111 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("lit_before_rst", 32'(anode != 3'b111), 32'd1);
    end
    #1 rst_n = 1'b0;
    #1;
    check("rst_anode", 32'(anode), 32'h7);
    check("rst_seg", 32'(segments), 32'h7F);
    check("rst_fs", 32'(frame_start), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_anode", 32'(anode), 32'h7);
    drive_dv(12'h789);
    @(negedge clk);
    check("post_rst_fs", 32'(frame_start), 32'd1);
    check("post_rst_seg", 32'(segments), 32'h10);
    repeat (FRAME) @(negedge clk);

    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
